// File: rtl/reg_file_mp_pkg.sv
// Shared types and sizing helpers for the multi-port MIPS register file.
package reg_file_mp_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int unsigned DEF_IO_IDX = 1;
  localparam int unsigned DBG_W      = 16;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'(1) << addr_w;
  endfunction

  // Debug slice-select width, never narrower than one bit
  function automatic int unsigned half_w_of(input int unsigned data_w);
    int unsigned n;
    n = data_w / DBG_W;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Register-file port bundle: write port, two read ports, switches, clear and debug.
interface reg_file_mp_if
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned SW_W   = 3
);
  localparam int unsigned HALF_W = half_w_of(DATA_W);

  logic              RegW;
  logic [ADDR_W-1:0] DR;
  logic [DATA_W-1:0] Reg_In;
  logic [ADDR_W-1:0] SR1;
  logic [ADDR_W-1:0] SR2;
  logic [DATA_W-1:0] ReadReg1;
  logic [DATA_W-1:0] ReadReg2;
  logic [SW_W-1:0]   SW;
  logic              Clear_Req;
  logic              Busy;
  logic [ADDR_W-1:0] Dbg_Sel;
  logic [HALF_W-1:0] Dbg_Half;
  logic [DBG_W-1:0]  Dbg_Out;

  modport master (
    output RegW, DR, Reg_In, SR1, SR2, SW, Clear_Req, Dbg_Sel, Dbg_Half,
    input  ReadReg1, ReadReg2, Busy, Dbg_Out
  );

  modport slave (
    input  RegW, DR, Reg_In, SR1, SR2, SW, Clear_Req, Dbg_Sel, Dbg_Half,
    output ReadReg1, ReadReg2, Busy, Dbg_Out
  );
endinterface

// File: rtl/reg_file_mp_dbg_mux.sv
// Combinational debug readout: picks one register and one 16-bit slice of it.
module reg_dbg_mux
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned HALF_W = 1
) (
  input  logic [DATA_W-1:0] regs_i [depth_of(ADDR_W)],
  input  logic [ADDR_W-1:0] sel_i,
  input  logic [HALF_W-1:0] half_i,
  output logic [DBG_W-1:0]  slice_c_o
);
  localparam int unsigned N_HALF = DATA_W / DBG_W;

  logic [DATA_W-1:0] word_c;

  // Register 0 is never swept or written, so it is forced to zero here
  always_comb begin
    slice_c_o = '0;
    word_c    = regs_i[sel_i];
    if (sel_i != '0 && 32'(half_i) < N_HALF) begin
      slice_c_o = DBG_W'(word_c >> (32'(half_i) * DBG_W));
    end
  end
endmodule

// File: rtl/reg_file_mp.sv
// MIPS register file: 1 write / 2 registered read ports, bypass, zero reg,
// switch-mapped IO register, post-reset clear sweep and a debug slice readout.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned IO_IDX = DEF_IO_IDX,
  parameter int unsigned SW_W   = 3
) (
  input logic          CLK,
  input logic          RST_N,
  reg_file_mp_if.slave bus
);
  localparam int unsigned DEPTH  = depth_of(ADDR_W);
  localparam int unsigned HALF_W = half_w_of(DATA_W);
  localparam logic [ADDR_W-1:0] IO_A = ADDR_W'(IO_IDX);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] regs_q [DEPTH];
  state_e            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DBG_W-1:0]  dbg_q;
  logic [DBG_W-1:0]  dbg_c;
  logic              idle_c;
  logic              wr_en_c;
  logic [DATA_W-1:0] sw_ext_c;

  assign idle_c   = (state_q == ST_IDLE);
  assign wr_en_c  = idle_c && bus.RegW && (bus.DR != '0) && (bus.DR != IO_A);
  assign sw_ext_c = DATA_W'(bus.SW);

  // Read-port value as seen at the coming edge, including bypass paths
  function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] idx,
                                               input logic [DATA_W-1:0] arr_word);
    if (!idle_c || idx == '0)          return '0;
    else if (idx == IO_A)              return sw_ext_c;
    else if (wr_en_c && bus.DR == idx) return bus.Reg_In;
    else                               return arr_word;
  endfunction

  always_comb begin
    rd1_d = rd_val(bus.SR1, regs_q[bus.SR1]);
    rd2_d = rd_val(bus.SR2, regs_q[bus.SR2]);
  end

  reg_dbg_mux #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .HALF_W(HALF_W)
  ) u_dbg_mux (
    .regs_i   (regs_q),
    .sel_i    (bus.Dbg_Sel),
    .half_i   (bus.Dbg_Half),
    .slice_c_o(dbg_c)
  );

  // Sweep FSM and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= ADDR_W'(1);
      rd1_q     <= '0;
      rd2_q     <= '0;
      dbg_q     <= '0;
    end else begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
      dbg_q <= dbg_c;
      case (state_q)
        ST_IDLE: begin
          if (bus.Clear_Req) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= ADDR_W'(1);
          end
        end
        ST_CLEAR: begin
          clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
          if (clr_ptr_q == LAST) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Storage array carries no reset; the sweep defines its contents
  always_ff @(posedge CLK) begin
    if (!idle_c) begin
      regs_q[clr_ptr_q] <= '0;
    end else begin
      regs_q[IO_A] <= sw_ext_c;
      if (wr_en_c) regs_q[bus.DR] <= bus.Reg_In;
    end
  end

  assign bus.ReadReg1 = rd1_q;
  assign bus.ReadReg2 = rd2_q;
  assign bus.Dbg_Out  = dbg_q;
  assign bus.Busy     = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus queues expectations by cycle, a monitor checks them.
module tb_reg_file_mp;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned SW_W   = 3;

  localparam int K_RR1  = 0;
  localparam int K_RR2  = 1;
  localparam int K_DBG  = 2;
  localparam int K_BUSY = 3;

  typedef struct {
    int unsigned cyc;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int          n_checks;
  int          n_pass;
  exp_t        sb[$];

  reg_file_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SW_W(SW_W)) bus ();

  reg_file_mp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .IO_IDX(1),
    .SW_W  (SW_W)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int kind, input logic [31:0] val, input int unsigned dly);
    exp_t e;
    e.cyc  = cyc + dly;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  function automatic string kname(input int kind);
    case (kind)
      K_RR1:   return "ReadReg1";
      K_RR2:   return "ReadReg2";
      K_DBG:   return "Dbg_Out";
      default: return "Busy";
    endcase
  endfunction

  // Monitor: compare every expectation that falls due in this cycle
  always @(negedge clk) begin
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [31:0] act;
        case (sb[i].kind)
          K_RR1:   act = bus.ReadReg1;
          K_RR2:   act = bus.ReadReg2;
          K_DBG:   act = 32'(bus.Dbg_Out);
          default: act = 32'(bus.Busy);
        endcase
        n_checks++;
        if (act !== sb[i].val)
          $display("FAIL %s cycle %0d: got %h expected %h", kname(sb[i].kind), cyc, act, sb[i].val);
        else
          n_pass++;
        sb.delete(i);
      end
    end
  end

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b1;
    bus.RegW      = 1'b0;
    bus.DR        = '0;
    bus.Reg_In    = '0;
    bus.SR1       = '0;
    bus.SR2       = '0;
    bus.SW        = '0;
    bus.Clear_Req = 1'b0;
    bus.Dbg_Sel   = '0;
    bus.Dbg_Half  = '0;
    #1 rst_n = 1'b0;

    // Reset held for three cycles
    step(1);
    expect_at(K_RR1, 32'h0, 0);
    expect_at(K_RR2, 32'h0, 0);
    expect_at(K_DBG, 32'h0, 0);
    expect_at(K_BUSY, 32'h1, 0);
    step(2);
    rst_n = 1'b1;
    expect_at(K_BUSY, 32'h1, 0);
    expect_at(K_BUSY, 32'h1, 30);
    expect_at(K_BUSY, 32'h0, 31);
    step(31);

    // Swept register reads zero
    bus.SR1     = 5'd5;
    bus.Dbg_Sel = 5'd5;
    expect_at(K_RR1, 32'h0, 1);
    expect_at(K_DBG, 32'h0, 1);
    step(1);

    // Plain write then read
    bus.RegW   = 1'b1;
    bus.DR     = 5'd7;
    bus.Reg_In = 32'hDEADBEEF;
    step(1);
    bus.RegW     = 1'b0;
    bus.SR1      = 5'd7;
    bus.Dbg_Sel  = 5'd7;
    bus.Dbg_Half = 1'b1;
    expect_at(K_RR1, 32'hDEADBEEF, 1);
    expect_at(K_DBG, 32'h0000DEAD, 1);
    step(1);
    n_checks++;
    if (bus.ReadReg1 !== 32'hDEADBEEF)
      $display("FAIL direct ReadReg1 write/read: got %h", bus.ReadReg1);
    else
      n_pass++;

    // Same-cycle bypass on both ports; debug sees the old value
    bus.RegW     = 1'b1;
    bus.DR       = 5'd9;
    bus.Reg_In   = 32'h12345678;
    bus.SR1      = 5'd9;
    bus.SR2      = 5'd9;
    bus.Dbg_Sel  = 5'd9;
    bus.Dbg_Half = 1'b0;
    expect_at(K_RR1, 32'h12345678, 1);
    expect_at(K_RR2, 32'h12345678, 1);
    expect_at(K_DBG, 32'h0, 1);
    step(1);
    n_checks++;
    if (bus.ReadReg2 !== 32'h12345678)
      $display("FAIL direct ReadReg2 bypass: got %h", bus.ReadReg2);
    else
      n_pass++;
    bus.RegW = 1'b0;
    bus.SR1  = 5'd7;
    expect_at(K_RR1, 32'hDEADBEEF, 1);
    expect_at(K_RR2, 32'h12345678, 1);
    expect_at(K_DBG, 32'h00005678, 1);
    step(1);

    // Register 0 ignores writes, including the bypass path
    bus.RegW   = 1'b1;
    bus.DR     = 5'd0;
    bus.Reg_In = 32'hFFFFFFFF;
    bus.SR1    = 5'd0;
    expect_at(K_RR1, 32'h0, 1);
    step(1);
    n_checks++;
    if (bus.ReadReg1 !== 32'h0)
      $display("FAIL direct ReadReg1 zero reg: got %h", bus.ReadReg1);
    else
      n_pass++;
    bus.RegW     = 1'b0;
    bus.Dbg_Sel  = 5'd0;
    bus.Dbg_Half = 1'b1;
    expect_at(K_RR1, 32'h0, 1);
    expect_at(K_DBG, 32'h0, 1);
    step(1);

    // IO register mirrors the switches and drops writes
    bus.SW     = 3'b101;
    bus.RegW   = 1'b1;
    bus.DR     = 5'd1;
    bus.Reg_In = 32'h0000AAAA;
    bus.SR1    = 5'd1;
    expect_at(K_RR1, 32'h5, 1);
    step(1);
    bus.RegW     = 1'b0;
    bus.Dbg_Sel  = 5'd1;
    bus.Dbg_Half = 1'b0;
    expect_at(K_RR1, 32'h5, 1);
    expect_at(K_DBG, 32'h5, 1);
    step(1);
    bus.SW  = 3'b010;
    bus.SR2 = 5'd1;
    expect_at(K_RR1, 32'h2, 1);
    expect_at(K_RR2, 32'h2, 1);
    step(1);
    n_checks++;
    if (bus.ReadReg1 !== 32'h2)
      $display("FAIL direct ReadReg1 IO reg: got %h", bus.ReadReg1);
    else
      n_pass++;

    // Clear sweep while in use
    bus.RegW   = 1'b1;
    bus.DR     = 5'd4;
    bus.Reg_In = 32'hCAFE0001;
    step(1);
    bus.RegW     = 1'b0;
    bus.SR1      = 5'd4;
    bus.Dbg_Sel  = 5'd4;
    bus.Dbg_Half = 1'b1;
    expect_at(K_RR1, 32'hCAFE0001, 1);
    expect_at(K_DBG, 32'h0000CAFE, 1);
    step(1);
    bus.Clear_Req = 1'b1;
    expect_at(K_BUSY, 32'h0, 0);
    expect_at(K_BUSY, 32'h1, 1);
    expect_at(K_BUSY, 32'h1, 31);
    expect_at(K_BUSY, 32'h0, 32);
    step(1);
    bus.Clear_Req = 1'b0;
    step(8);
    // Write to an already swept slot must be dropped; reads return zero while busy
    bus.RegW   = 1'b1;
    bus.DR     = 5'd4;
    bus.Reg_In = 32'h11112222;
    bus.SR2    = 5'd7;
    expect_at(K_RR1, 32'h0, 1);
    expect_at(K_RR2, 32'h0, 1);
    step(1);
    bus.RegW = 1'b0;
    step(10);
    // A second request during the sweep must not extend it
    bus.Clear_Req = 1'b1;
    step(1);
    bus.Clear_Req = 1'b0;
    step(11);
    bus.SR1      = 5'd4;
    bus.SR2      = 5'd1;
    bus.Dbg_Sel  = 5'd4;
    bus.Dbg_Half = 1'b1;
    expect_at(K_RR1, 32'h0, 1);
    expect_at(K_RR2, 32'h2, 1);
    expect_at(K_DBG, 32'h0, 1);
    step(1);
    bus.SR1 = 5'd7;
    expect_at(K_RR1, 32'h0, 1);
    step(3);

    foreach (sb[i]) begin
      n_checks++;
      $display("FAIL %s never checked: expected %h at cycle %0d", kname(sb[i].kind), sb[i].val, sb[i].cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
